// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared state encoding and sizing helper for seq_adder
//
// Purpose : state enum for the seq_adder control FSM and the width function
//           used to size its step counter.
// Ports   : none (package).
package seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold a step index 0..nstep-1; never less than 1 so a
    // single-cycle configuration still has a legal counter vector.
    function automatic int step_cnt_width(input int nstep);
        return (nstep <= 1) ? 1 : $clog2(nstep);
    endfunction

endpackage

// File: rtl/seq_adder_digit_adder.sv
// rtl/seq_adder_digit_adder.sv - combinational DIGIT-bit ripple adder from half-adder cells
//
// Purpose : s = x + y + ci over DIGIT bits, co = carry out of the top bit.
//           Each bit position is a full adder made of two half-adder cells
//           whose carries are ORed.
// Ports   : i_x  [DIGIT] operand digit X
//           i_y  [DIGIT] operand digit Y
//           i_ci [1]     carry in
//           o_s  [DIGIT] sum digit
//           o_co [1]     carry out
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_x,
    input  logic [DIGIT-1:0] i_y,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_s,
    output logic             o_co
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar g = 0; g < DIGIT; g++) begin : g_bit
        logic w_hs;
        logic w_hc_xy;
        logic w_hc_sc;

        // first half-adder: x + y
        assign w_hs    = i_x[g] ^ i_y[g];
        assign w_hc_xy = i_x[g] & i_y[g];
        // second half-adder: partial sum + incoming carry
        assign o_s[g]   = w_hs ^ w_c[g];
        assign w_hc_sc  = w_hs & w_c[g];
        // both half-adder carries can never be 1 together, so OR is exact
        assign w_c[g+1] = w_hc_xy | w_hc_sc;
    end

    assign o_co = w_c[DIGIT];

endmodule

// File: rtl/seq_adder.sv
// rtl/seq_adder.sv - multi-cycle WIDTH-bit adder, DIGIT bits per clock, valid/ready both sides
//
// Purpose : adds a + b + cin one DIGIT-wide slice per clock, LSB slice first,
//           and reports sum, carry-out and two's-complement overflow.
// Ports   : clk        rising-edge clock
//           rst_n      asynchronous active-low reset
//           in_valid   operands valid          in_ready   ready for operands
//           a, b [W]   operands                cin        carry in
//           out_valid  result valid            out_ready  consumer accepts
//           sum [W]    a+b+cin mod 2^W         cout       carry out of MSB
//           ovf        signed overflow
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = step_cnt_width(NSTEP);
    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_param_check
        $error("seq_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_step;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic [DIGIT-1:0] w_x;
    logic [DIGIT-1:0] w_y;
    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_step == LAST_STEP);
    assign w_x      = r_a[int'(r_step) * DIGIT +: DIGIT];
    assign w_y      = r_b[int'(r_step) * DIGIT +: DIGIT];

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .i_x  (w_x),
        .i_y  (w_y),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_step      <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next == ST_DONE);
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_step  <= '0;
                r_sum   <= '0;
            end else if (r_state == ST_RUN) begin
                r_sum[int'(r_step) * DIGIT +: DIGIT] <= w_s;
                r_carry <= w_co;
                if (w_last) begin
                    // w_s[DIGIT-1] is the final sum MSB on this edge.
                    r_cout <= w_co;
                    r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                              (w_s[DIGIT-1] != r_a[WIDTH-1]);
                end else begin
                    // Held at the last index so the slice select stays in range
                    // after the final digit.
                    r_step <= r_step + CW'(1);
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_adder.sv
// tb/tb_seq_adder.sv - directed and reference-model bench for seq_adder
module tb_seq_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        iv8 = 1'b0, ir8, cin8 = 1'b0, ov8, or8 = 1'b0, co8, of8;
    logic [7:0]  a8 = '0, b8 = '0, s8;

    logic        iv16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir4, ov4, co4, of4, ir16, ov16, co16, of16;
    logic [15:0] s4, s16;

    int n_tests = 0;
    int n_fail  = 0;

    seq_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
    );

    seq_adder #(.WIDTH(16), .DIGIT(4)) dut16_4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir4), .a(a16), .b(b16),
        .cin(cin16), .out_valid(ov4), .out_ready(1'b1), .sum(s4), .cout(co4), .ovf(of4)
    );

    seq_adder #(.WIDTH(16), .DIGIT(16)) dut16_16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .out_valid(ov16), .out_ready(1'b1), .sum(s16), .cout(co16), .ovf(of16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 8-bit transaction: accept, optional in_valid poke during RUN,
    // latency check, result check, optional stall, then output handshake.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo,
                        input int hold, input bit poke);
        int lat;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; iv8 = 1'b1;
        chk("in_ready_idle", 32'(ir8), 32'd1);
        @(negedge clk);
        iv8 = 1'b0;
        // operands change after the accept edge; result must not follow
        a8 = ~ta; b8 = ~tb; cin8 = ~tc;
        lat = 0;
        while (!ov8 && lat < 30) begin
            if (ir8) chk("in_ready_run", 32'(ir8), 32'd0);
            if (poke && lat == 2) begin
                iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
            end else begin
                iv8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        iv8 = 1'b0;
        chk("latency8", 32'(lat), 32'd8);
        chk("sum8", 32'(s8), 32'(es));
        chk("cout8", 32'(co8), 32'(ec));
        chk("ovf8", 32'(of8), 32'(eo));
        chk("in_ready_done", 32'(ir8), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ov8), 32'd1);
            chk("hold_sum", 32'(s8), 32'(es));
            chk("hold_cout", 32'(co8), 32'(ec));
            chk("hold_ovf", 32'(of8), 32'(eo));
            chk("hold_in_ready", 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("ov_fall", 32'(ov8), 32'd0);
        chk("in_ready_rise", 32'(ir8), 32'd1);
    endtask

    // One 16-bit transaction into both 16-bit instances; the reference
    // model is plain integer addition.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        logic [16:0] ref_full;
        logic        ref_ovf;
        bit          seen4, seen16;
        ref_full = {1'b0, ta} + {1'b0, tb} + 17'(tc);
        ref_ovf  = (ta[15] == tb[15]) && (ref_full[15] != ta[15]);
        @(negedge clk);
        a16 = ta; b16 = tb; cin16 = tc; iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = ~tc;
        seen4 = 0; seen16 = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (!seen4 && ov4) begin
                seen4 = 1;
                chk("lat16_4", 32'(k), 32'd4);
                chk("sum16_4", 32'(s4), 32'(ref_full[15:0]));
                chk("cout16_4", 32'(co4), 32'(ref_full[16]));
                chk("ovf16_4", 32'(of4), 32'(ref_ovf));
            end
            if (!seen16 && ov16) begin
                seen16 = 1;
                chk("lat16_16", 32'(k), 32'd1);
                chk("sum16_16", 32'(s16), 32'(ref_full[15:0]));
                chk("cout16_16", 32'(co16), 32'(ref_full[16]));
                chk("ovf16_16", 32'(of16), 32'(ref_ovf));
            end
        end
        chk("seen16_4", 32'(seen4), 32'd1);
        chk("seen16_16", 32'(seen16), 32'd1);
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_sum", 32'(s8), 32'd0);
        chk("rst_cout", 32'(co8), 32'd0);
        chk("rst_ovf", 32'(of8), 32'd0);
        chk("rst_out_valid16", 32'(ov16), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // basic, wrap, signed overflow, both-negative with stall, ignored poke
        run8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0, 0);
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 0);
        run8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 5, 0);
        run8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 0, 1);

        // reset in RUN with step counter at 3: 0xFF+0x00 has sum 0x07 by then
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("partial_sum", 32'(s8), 32'h07);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(ov8), 32'd0);
        chk("abort_sum", 32'(s8), 32'd0);
        chk("abort_in_ready", 32'(ir8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 0);

        // 16-bit: corner vectors, then random pairs
        run16(16'hFFFF, 16'h0000, 1'b1);
        run16(16'h7FFF, 16'h0001, 1'b0);
        run16(16'h8000, 16'h8000, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
